// File: rtl/div_request_arbiter_pkg.sv
// div_request_arbiter_pkg: shared FSM state and response error encodings
package div_request_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
    typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_DZ = 2'b01, ERR_OVF = 2'b10, ERR_TO = 2'b11} err_t;
endpackage

// File: rtl/div_request_arbiter_rr_arbiter.sv
// rr_arbiter: grants the first active request at or after the pointer, wrapping around
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // scan from the farthest slot back so the nearest active request wins
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/div_request_arbiter.sv
// div_request_arbiter: shares one divider core among requesters with pre-checks and a watchdog
module div_request_arbiter
    import div_request_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = 12,
    parameter int DW      = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_aq,
    input  logic [N_REQ*DW-1:0] req_d,
    output logic [N_REQ-1:0]    ack,
    output logic                div_start,
    output logic [AW-1:0]       div_aq,
    output logic [DW-1:0]       div_d,
    input  logic                div_done,
    input  logic [DW-1:0]       div_q,
    input  logic [DW-1:0]       div_rem,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_id,
    output logic [DW-1:0]       rsp_q,
    output logic [DW-1:0]       rsp_rem,
    output logic [1:0]          rsp_err,
    output logic                busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t state, state_nx;
    err_t err_r, pre_err;
    logic [IW-1:0] rr_ptr, id_r, g_idx;
    logic [N_REQ-1:0] gnt;
    logic g_any, prev_done, rise, expired;
    logic [AW-1:0] aq_r, sel_aq;
    logic [DW-1:0] d_r, sel_d, q_r, rem_r;
    logic [TW-1:0] wdog;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (.req(req), .ptr(rr_ptr), .gnt(gnt), .idx(g_idx), .any(g_any));

    assign sel_aq  = req_aq[int'(g_idx)*AW +: AW];
    assign sel_d   = req_d[int'(g_idx)*DW +: DW];
    assign pre_err = (sel_d == '0) ? ERR_DZ : (sel_aq[AW-1:DW] >= sel_d) ? ERR_OVF : ERR_OK;
    assign rise    = div_done & ~prev_done;
    assign expired = wdog == TW'(TIMEOUT - 1);

    // ack is only meaningful while the reset is released and the arbiter is idle
    assign ack       = (rst && state == IDLE) ? gnt : '0;
    assign div_start = state == LAUNCH;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;
    assign div_aq    = aq_r;
    assign div_d     = d_r;
    assign rsp_id    = 3'(id_r);
    assign rsp_q     = q_r;
    assign rsp_rem   = rem_r;
    assign rsp_err   = err_r;

    // next state: a done edge beats the watchdog in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (g_any) state_nx = (pre_err == ERR_OK) ? LAUNCH : RESP;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (rise || expired) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, operand capture, result latching and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_r      <= '0;
            aq_r      <= '0;
            d_r       <= '0;
            q_r       <= '0;
            rem_r     <= '0;
            err_r     <= ERR_OK;
            wdog      <= '0;
            prev_done <= 1'b0;
        end else begin
            state     <= state_nx;
            prev_done <= div_done;
            if (state == IDLE && g_any) begin
                id_r   <= g_idx;
                aq_r   <= sel_aq;
                d_r    <= sel_d;
                err_r  <= pre_err;
                q_r    <= '0;
                rem_r  <= '0;
                rr_ptr <= (int'(g_idx) == N_REQ - 1) ? '0 : g_idx + 1'b1;
            end
            if (state == LAUNCH) wdog <= '0;
            if (state == WAIT) begin
                wdog <= wdog + 1'b1;
                if (rise) begin
                    q_r   <= div_q;
                    rem_r <= div_rem;
                end else if (expired) err_r <= ERR_TO;
            end
        end
    end
endmodule

// File: tb/tb_div_request_arbiter.sv
// tb_div_request_arbiter: vector table plus scoreboard checking of the divider arbiter with a core model
module tb_div_request_arbiter;
    localparam int TIMEOUT = 64;
    localparam int LAT = 7;

    typedef struct {int id; int aq; int d; int q; int rem; int err;} vec_t;
    typedef struct {int id; int q; int rem; int err;} rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] req = '0;
    logic [47:0] req_aq = '0;
    logic [23:0] req_d = '0;
    logic [3:0] ack;
    logic div_start;
    logic [11:0] div_aq;
    logic [5:0] div_d;
    logic div_done = 1'b0;
    logic [5:0] div_q = '0, div_rem = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [2:0] rsp_id;
    logic [5:0] rsp_q, rsp_rem;
    logic [1:0] rsp_err;
    logic busy;

    int total = 0, bad = 0, starts = 0, core_cnt = 0;
    bit stub = 1'b0;
    logic [11:0] c_aq = '0;
    logic [5:0] c_d = '0;
    vec_t vecs[10];
    rsp_t sb[$];
    rsp_t e_r;

    always #5 clk = ~clk;

    div_request_arbiter #(.N_REQ(4), .AW(12), .DW(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_aq(req_aq), .req_d(req_d), .ack(ack),
        .div_start(div_start), .div_aq(div_aq), .div_d(div_d), .div_done(div_done),
        .div_q(div_q), .div_rem(div_rem), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_rem(rsp_rem), .rsp_err(rsp_err), .busy(busy)
    );

    // divider core: done drops on start and rises LAT cycles later (never when stubbed)
    always @(posedge clk) begin
        if (div_start) begin
            div_done <= 1'b0;
            core_cnt <= LAT;
            c_aq <= div_aq;
            c_d <= div_d;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !stub) begin
                div_done <= 1'b1;
                div_q <= (c_d == 0) ? 6'd0 : 6'(c_aq / c_d);
                div_rem <= (c_d == 0) ? 6'd0 : 6'(c_aq % c_d);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (div_start) starts++;

    // scoreboard: every accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id %0d want none", rsp_id);
            end else begin
                e_r = sb.pop_front();
                chk("rsp_id", rsp_id, e_r.id);
                chk("rsp_q", rsp_q, e_r.q);
                chk("rsp_rem", rsp_rem, e_r.rem);
                chk("rsp_err", rsp_err, e_r.err);
            end
        end
    end

    task automatic drive(input int id, input int aq, input int d);
        req_aq[id*12 +: 12] = 12'(aq);
        req_d[id*6 +: 6] = 6'(d);
        req[id] = 1'b1;
    endtask

    task automatic wait_ack(output int idx);
        idx = -1;
        for (int c = 0; c < 300 && idx < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
        end
        if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL ack_wait: got none want ack");
        end
    endtask

    task automatic drop_after_edge(input int id);
        @(posedge clk);
        #1 req[id] = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_wait: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input vec_t v);
        int got, s0;
        @(posedge clk);
        #1 drive(v.id, v.aq, v.d);
        s0 = starts;
        wait_ack(got);
        chk("ack_id", got, v.id);
        sb.push_back('{v.id, v.q, v.rem, v.err});
        drop_after_edge(v.id);
        @(negedge clk);
        chk("ack_pulse", ack, 0);
        wait_rsp();
        chk("start_count", starts - s0, (v.err == 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int got, n;
        vecs[0] = '{0, 88, 8, 11, 0, 0};
        vecs[1] = '{3, 1000, 0, 0, 0, 1};
        vecs[2] = '{1, 1876, 16, 0, 0, 2};
        vecs[3] = '{2, 1876, 56, 33, 28, 0};
        vecs[4] = '{3, 4095, 63, 0, 0, 2};
        vecs[5] = '{0, 4031, 63, 63, 62, 0};
        vecs[6] = '{1, 0, 1, 0, 0, 0};
        vecs[7] = '{2, 1000, 63, 15, 55, 0};
        vecs[8] = '{0, 640, 10, 0, 0, 2};
        vecs[9] = '{1, 639, 10, 63, 9, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_start", div_start, 0);
        chk("rst_err", rsp_err, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // two simultaneous requests with the pointer at 0
        @(posedge clk);
        #1 drive(1, 75, 11);
        drive(2, 2000, 51);
        wait_ack(got);
        chk("rr_first", got, 1);
        sb.push_back('{1, 6, 9, 0});
        drop_after_edge(1);
        wait_ack(got);
        chk("rr_second", got, 2);
        sb.push_back('{2, 39, 11, 0});
        drop_after_edge(2);
        wait_rsp();

        foreach (vecs[k]) run_op(vecs[k]);

        // stubbed core: watchdog abort, then a stalled response
        stub = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 drive(0, 88, 8);
        wait_ack(got);
        chk("to_ack", got, 0);
        sb.push_back('{0, 0, 0, 3});
        drop_after_edge(0);
        @(negedge clk);
        chk("to_start", div_start, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 200);
        chk("to_latency", n, TIMEOUT + 1);
        drive(1, 75, 11);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, 0);
            chk("hold_err", rsp_err, 3);
            chk("hold_q", rsp_q, 0);
            chk("hold_ack", ack, 0);
        end
        @(posedge clk);
        #1 stub = 1'b0;
        rsp_ready = 1'b1;
        wait_ack(got);
        chk("after_hold_ack", got, 1);
        sb.push_back('{1, 6, 9, 0});
        drop_after_edge(1);
        wait_rsp();

        // reset while waiting on the core
        @(posedge clk);
        #1 drive(2, 2000, 51);
        wait_ack(got);
        drop_after_edge(2);
        @(negedge clk);
        chk("mid_start", div_start, 1);
        @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", rsp_valid, 0);
        chk("mid_start_off", div_start, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        run_op('{2, 2000, 51, 39, 11, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
